// File: rtl/ev22_datapath_sequencer.sv
// ev22_datapath_sequencer
// Multi-cycle control FSM for the EV22 16-bit datapath. It fetches
// instruction words over a req/ack handshake, decodes the operand selects
// for the register read mux, strobes the operand/ALU latch, and issues the
// register write-back. It flags illegal selects and stops on HALT.
//
// Ports:
//   clk          rising-edge system clock
//   n_reset      asynchronous active-low reset
//   Run          level; enables execution out of IDLE
//   Instr_Req    program-memory fetch request (high throughout FETCH)
//   Instr_Ack    program-memory data valid, one-cycle pulse
//   Instr_Data   instruction word: [15:11] opcode, [10:6] Sel_A/dest, [5:0] Sel_B
//   PC           address of the word being fetched
//   Sel_A/Sel_B  operand selects, held from DECODE to the next DECODE
//   ALU_Op       opcode forwarded to the ALU
//   updateBlock  one-cycle operand/ALU latch strobe (EXEC)
//   Write_En     one-cycle register write strobe (WB)
//   Write_Addr   destination register, valid while Write_En is high
//   Illegal      sticky illegal-select flag
//   Halted       high while in HALT
module ev22_datapath_sequencer #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned WREG_SEL = 34,
  parameter int unsigned PI0_SEL  = 28,
  parameter int unsigned PI1_SEL  = 29
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            Run,
  output logic            Instr_Req,
  input  logic            Instr_Ack,
  input  logic [15:0]     Instr_Data,
  output logic [PC_W-1:0] PC,
  output logic [4:0]      Sel_A,
  output logic [5:0]      Sel_B,
  output logic [4:0]      ALU_Op,
  output logic            updateBlock,
  output logic            Write_En,
  output logic [4:0]      Write_Addr,
  output logic            Illegal,
  output logic            Halted
);

  localparam logic [5:0] WREG_CODE = 6'(WREG_SEL);
  localparam logic [4:0] PI0_CODE  = 5'(PI0_SEL);
  localparam logic [4:0] PI1_CODE  = 5'(PI1_SEL);
  localparam logic [4:0] OP_NOP    = 5'd0;
  localparam logic [4:0] OP_HALT   = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] ir;
  logic [4:0]  ir_op;
  logic [4:0]  ir_a;
  logic [5:0]  ir_b;
  logic        sel_illegal;
  logic        wb_write;

  always_comb begin
    ir_op = ir[15:11];
    ir_a  = ir[10:6];
    ir_b  = ir[5:0];
    // Register codes 0..29 are readable; Sel_B additionally reaches the
    // working register. Everything else is an illegal select.
    sel_illegal = (ir_a > 5'd29) || ((ir_b > 6'd29) && (ir_b != WREG_CODE));
    // Opcodes 1..15 write back, except into the read-only input ports.
    wb_write = (ALU_Op != OP_NOP) && !ALU_Op[4] &&
               (Sel_A != PI0_CODE) && (Sel_A != PI1_CODE);
  end

  always_comb begin
    state_nx    = state;
    Instr_Req   = 1'b0;
    updateBlock = 1'b0;
    Write_En    = 1'b0;
    Halted      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Run) state_nx = S_FETCH;
      end
      S_FETCH: begin
        Instr_Req = 1'b1;
        if (Instr_Ack) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (sel_illegal)           state_nx = Run ? S_FETCH : S_IDLE;
        else if (ir_op == OP_HALT) state_nx = S_HALT;
        else if (ir_op == OP_NOP)  state_nx = S_FETCH;
        else                       state_nx = S_EXEC;
      end
      S_EXEC: begin
        updateBlock = 1'b1;
        state_nx    = S_WB;
      end
      S_WB: begin
        Write_En = wb_write;
        state_nx = Run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
    Write_Addr = Write_En ? Sel_A : '0;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= S_IDLE;
      ir      <= '0;
      PC      <= '0;
      Sel_A   <= '0;
      Sel_B   <= '0;
      ALU_Op  <= '0;
      Illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == S_FETCH) && Instr_Ack) begin
        ir <= Instr_Data;
        PC <= PC + PC_W'(1);
      end
      if (state == S_DECODE) begin
        Sel_A  <= ir_a;
        Sel_B  <= ir_b;
        ALU_Op <= ir_op;
        if (sel_illegal) Illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ev22_datapath_sequencer.sv
module tb_ev22_datapath_sequencer;

  logic        clk = 1'b0;
  logic        n_reset = 1'b1;
  logic        Run = 1'b0;
  logic        Instr_Ack = 1'b0;
  logic [15:0] Instr_Data = '0;
  logic        Instr_Req;
  logic [7:0]  PC;
  logic [4:0]  Sel_A;
  logic [5:0]  Sel_B;
  logic [4:0]  ALU_Op;
  logic        updateBlock;
  logic        Write_En;
  logic [4:0]  Write_Addr;
  logic        Illegal;
  logic        Halted;

  ev22_datapath_sequencer #(
    .PC_W(8), .WREG_SEL(34), .PI0_SEL(28), .PI1_SEL(29)
  ) dut (
    .clk(clk), .n_reset(n_reset), .Run(Run),
    .Instr_Req(Instr_Req), .Instr_Ack(Instr_Ack), .Instr_Data(Instr_Data),
    .PC(PC), .Sel_A(Sel_A), .Sel_B(Sel_B), .ALU_Op(ALU_Op),
    .updateBlock(updateBlock), .Write_En(Write_En), .Write_Addr(Write_Addr),
    .Illegal(Illegal), .Halted(Halted)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges since reset was released.
  int cyc;
  always @(posedge clk or negedge n_reset)
    if (!n_reset) cyc <= 0;
    else          cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: each acknowledged fetch schedules the
  // externally visible events of that instruction at absolute cycles.
  localparam int NEVER = 1 << 30;
  bit ub_exp[int];
  bit we_exp[int];
  int wa_exp[int];
  int sa_exp[int];
  int sb_exp[int];
  int pc_at[int];
  int cur_pc, pc_model, ill_from, halt_from, nf_exp;
  bit chk_en = 1'b0;

  task automatic model_reset();
    ub_exp.delete(); we_exp.delete(); wa_exp.delete();
    sa_exp.delete(); sb_exp.delete(); pc_at.delete();
    cur_pc = 0; pc_model = 0;
    ill_from = NEVER; halt_from = NEVER; nf_exp = NEVER;
  endtask

  // ack_cyc is the cycle right after the ack is sampled (the decode cycle).
  task automatic model_instr(input logic [15:0] d, input int ack_cyc);
    int op, ra, rb;
    op = 32'(d[15:11]);
    ra = 32'(d[10:6]);
    rb = 32'(d[5:0]);
    pc_model = (pc_model + 1) % 256;
    pc_at[ack_cyc] = pc_model;
    if (ra > 29 || (rb > 29 && rb != 34)) begin
      if (ill_from == NEVER) ill_from = ack_cyc + 1;
      nf_exp = Run ? ack_cyc + 1 : NEVER;
    end else if (op == 31) begin
      halt_from = ack_cyc + 1;
      nf_exp = NEVER;
    end else if (op == 0) begin
      nf_exp = ack_cyc + 1;
    end else begin
      ub_exp[ack_cyc + 1] = 1'b1;
      sa_exp[ack_cyc + 1] = ra;
      sb_exp[ack_cyc + 1] = rb;
      if (op <= 15 && ra != 28 && ra != 29) begin
        we_exp[ack_cyc + 2] = 1'b1;
        wa_exp[ack_cyc + 2] = ra;
      end
      nf_exp = ack_cyc + 3;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (pc_at.exists(cyc)) cur_pc = pc_at[cyc];
      chk("updateBlock", 32'(updateBlock), 32'(ub_exp.exists(cyc)));
      chk("Write_En", 32'(Write_En), 32'(we_exp.exists(cyc)));
      chk("Write_Addr", 32'(Write_Addr), we_exp.exists(cyc) ? 32'(wa_exp[cyc]) : 32'd0);
      if (ub_exp.exists(cyc)) begin
        chk("Sel_A", 32'(Sel_A), 32'(sa_exp[cyc]));
        chk("Sel_B", 32'(Sel_B), 32'(sb_exp[cyc]));
      end
      chk("Illegal", 32'(Illegal), 32'(cyc >= ill_from));
      chk("Halted", 32'(Halted), 32'(cyc >= halt_from));
      chk("PC", 32'(PC), 32'(cur_pc));
    end
  end

  // Entered on a falling edge. Waits for the request, holds off the ack for
  // dly cycles, then pulses it. Returns on the falling edge of the decode cycle.
  task automatic fetch(input logic [15:0] d, input int dly, output int ack_cyc);
    int g, reqs;
    g = 0;
    reqs = 0;
    while (!Instr_Req && g < 12) begin
      @(negedge clk);
      g++;
    end
    chk("fetch_start", 32'(cyc), 32'(nf_exp));
    Instr_Data = d;
    for (int i = 0; i < dly; i++) begin
      reqs += 32'(Instr_Req);
      @(negedge clk);
    end
    reqs += 32'(Instr_Req);
    Instr_Ack = 1'b1;
    ack_cyc = cyc + 1;
    model_instr(d, ack_cyc);
    @(negedge clk);
    Instr_Ack = 1'b0;
    Instr_Data = '0;
    chk("req_cycles", 32'(reqs), 32'(dly + 1));
    chk("req_drop", 32'(Instr_Req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    model_reset();
    #1 n_reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(Instr_Req), 32'd0);
    chk("rst_pc", 32'(PC), 32'd0);
    chk("rst_sel_a", 32'(Sel_A), 32'd0);
    chk("rst_sel_b", 32'(Sel_B), 32'd0);
    chk("rst_alu_op", 32'(ALU_Op), 32'd0);
    chk("rst_ub", 32'(updateBlock), 32'd0);
    chk("rst_we", 32'(Write_En), 32'd0);
    chk("rst_wa", 32'(Write_Addr), 32'd0);
    chk("rst_illegal", 32'(Illegal), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);

    Run = 1'b1;
    n_reset = 1'b1;
    nf_exp = 1;
    chk_en = 1'b1;

    // Illegal Sel_B = 35.
    fetch(16'h0823, 0, a);
    chk("lit_pc_1", 32'(PC), 32'd1);
    @(negedge clk);
    chk("lit_illegal", 32'(Illegal), 32'd1);
    chk("lit_no_ub", 32'(updateBlock), 32'd0);

    // op1, A=1, B=34 (working register).
    fetch(16'h0862, 0, a);
    @(negedge clk);
    chk("lit_ub", 32'(updateBlock), 32'd1);
    chk("lit_sel_a", 32'(Sel_A), 32'd1);
    chk("lit_sel_b", 32'(Sel_B), 32'd34);
    chk("lit_alu_op", 32'(ALU_Op), 32'd1);
    @(negedge clk);
    chk("lit_we", 32'(Write_En), 32'd1);
    chk("lit_wa", 32'(Write_Addr), 32'd1);

    // Write to read-only PI0 is suppressed.
    fetch(16'h0F00, 0, a);
    @(negedge clk);
    chk("lit_pi0_ub", 32'(updateBlock), 32'd1);
    @(negedge clk);
    chk("lit_pi0_we", 32'(Write_En), 32'd0);

    // op20, A=3, B=5: executes, no write-back.
    fetch(16'hA0C5, 0, a);

    // Ack held off 5 cycles.
    fetch(16'h0862, 5, a);
    chk("lit_pc_5", 32'(PC), 32'd5);

    // Run drops mid-instruction: completes, then idles.
    fetch(16'h0862, 0, a);
    Run = 1'b0;
    nf_exp = NEVER;
    repeat (6) begin
      @(negedge clk);
      chk("idle_no_req", 32'(Instr_Req), 32'd0);
    end
    Run = 1'b1;
    nf_exp = cyc + 1;

    // NOPs up to the PC wrap.
    while (pc_model != 255) fetch(16'h0000, 0, a);
    fetch(16'h0000, 0, a);
    chk("lit_pc_wrap", 32'(PC), 32'd0);

    // HALT: Run has no effect, no further fetches.
    fetch(16'hF800, 0, a);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) Run = 1'b0;
      if (i == 7) Run = 1'b1;
      chk("halt_no_req", 32'(Instr_Req), 32'd0);
      chk("lit_halted", 32'(Halted), 32'd1);
    end

    // Asynchronous reset between clock edges.
    chk_en = 1'b0;
    @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    chk("arst_halted", 32'(Halted), 32'd0);
    chk("arst_pc", 32'(PC), 32'd0);
    chk("arst_illegal", 32'(Illegal), 32'd0);

    // Reset during a pending fetch; a late ack must be ignored.
    @(negedge clk);
    model_reset();
    n_reset = 1'b1;
    @(negedge clk);
    chk("hs_req_up", 32'(Instr_Req), 32'd1);
    #2 n_reset = 1'b0;
    Run = 1'b0;
    #1 chk("hs_req_drop", 32'(Instr_Req), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    chk_en = 1'b1;
    Instr_Ack = 1'b1;
    Instr_Data = 16'h0862;
    @(negedge clk);
    Instr_Ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hs_no_req", 32'(Instr_Req), 32'd0);
      chk("hs_pc", 32'(PC), 32'd0);
    end
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
